// File: rtl/nvram_responder.sv
// Save-RAM responder: the APF bridge streams save data in and out, the core uses the RAM otherwise.
// Optional macro NVRAM_AUTOSAVE_EN: request an upload after AUTOSAVE_CYCLES quiet cycles while dirty.
module nvram_responder #(
    parameter int AW              = 13,
    parameter int DW              = 8,
    parameter int SAVE_IDX        = 3,
    parameter int AUTOSAVE_CYCLES = 74_000_000
) (
    input  logic          clk_memory,
    input  logic          reset_n,

    input  logic          nvram_download,
    input  logic          nvram_upload,
    input  logic          nvram_wr,
    input  logic [AW-1:0] nvram_addr,
    input  logic [DW-1:0] nvram_dout,
    input  logic          nvram_rd,
    output logic [DW-1:0] nvram_din,
    output logic          nvram_upload_req,
    output logic [15:0]   nvram_upload_index,

    input  logic [AW-1:0] core_addr,
    input  logic          core_wr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    input  logic          core_save,
    output logic          core_busy,
    output logic          dirty
);

    if (DW != 8 && DW != 16) begin : g_bad_dw
        $error("nvram_responder: DW must be 8 or 16");
    end
    if (AUTOSAVE_CYCLES < 2) begin : g_bad_autosave
        $error("nvram_responder: AUTOSAVE_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, DOWNLOAD, UPLOAD, REQUEST} state_t;
    state_t state;

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_q;
    logic          brd_vld, crd_vld;

    // Ownership follows the bridge levels directly, so the core regains the RAM
    // in the very cycle a transfer level drops.
    logic          bridge_own;
    logic          core_we, bridge_we, bridge_re;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic          dl_done, ul_done;
    logic          autosave_hit;
    logic          save_go;

    assign nvram_upload_index = 16'(SAVE_IDX);

    assign bridge_own = nvram_download | nvram_upload;
    assign core_we    = ~bridge_own & core_wr;
    assign bridge_we  = (state == DOWNLOAD) & nvram_download & nvram_wr;
    assign bridge_re  = (state == UPLOAD) & nvram_upload & nvram_rd;
    assign ram_addr   = bridge_own ? nvram_addr : core_addr;
    assign ram_wdata  = bridge_own ? nvram_dout : core_wdata;
    assign ram_we     = reset_n & (bridge_we | core_we);
    assign dl_done    = (state == DOWNLOAD) & ~nvram_download;
    assign ul_done    = (state == UPLOAD) & ~nvram_upload;
    assign save_go    = (core_save & dirty) | autosave_hit;

`ifdef NVRAM_AUTOSAVE_EN
    localparam int CW = $clog2(AUTOSAVE_CYCLES);
    logic [CW-1:0] as_cnt;

    // Fires on the edge where the count would reach AUTOSAVE_CYCLES-1.
    assign autosave_hit = (state == IDLE) & dirty & ~core_we &
                          (as_cnt == CW'(AUTOSAVE_CYCLES - 2));

    always_ff @(posedge clk_memory) begin
        if (!reset_n)
            as_cnt <= '0;
        else if (core_we || state != IDLE || !dirty || autosave_hit)
            as_cnt <= '0;
        else
            as_cnt <= as_cnt + 1'b1;
    end
`else
    assign autosave_hit = 1'b0;
`endif

    always_ff @(posedge clk_memory) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        rd_q <= mem[ram_addr];
    end

    always_ff @(posedge clk_memory) begin
        if (!reset_n) begin
            state            <= IDLE;
            nvram_din        <= '0;
            core_rdata       <= '0;
            nvram_upload_req <= 1'b0;
            core_busy        <= 1'b0;
            dirty            <= 1'b0;
            brd_vld          <= 1'b0;
            crd_vld          <= 1'b0;
        end else begin
            brd_vld <= bridge_re;
            crd_vld <= ~bridge_own;
            if (brd_vld)
                nvram_din <= rd_q;
            if (crd_vld)
                core_rdata <= rd_q;

            // A core write landing with a transfer completion wins.
            if (core_we)
                dirty <= 1'b1;
            else if (dl_done || ul_done)
                dirty <= 1'b0;

            case (state)
                IDLE: begin
                    if (nvram_download) begin
                        state     <= DOWNLOAD;
                        core_busy <= 1'b1;
                    end else if (nvram_upload) begin
                        state     <= UPLOAD;
                        core_busy <= 1'b1;
                    end else if (save_go) begin
                        state            <= REQUEST;
                        nvram_upload_req <= 1'b1;
                    end
                end
                DOWNLOAD: begin
                    if (!nvram_download) begin
                        state     <= IDLE;
                        core_busy <= 1'b0;
                    end
                end
                UPLOAD: begin
                    if (!nvram_upload) begin
                        state     <= IDLE;
                        core_busy <= 1'b0;
                    end
                end
                REQUEST: begin
                    if (nvram_upload) begin
                        state            <= UPLOAD;
                        nvram_upload_req <= 1'b0;
                        core_busy        <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nvram_responder.sv
// Randomized bench for nvram_responder against a word-array model of the save RAM.
module tb_nvram_responder;
    localparam int AW = 13;
    localparam int DW = 8;

    logic          clk_memory = 1'b0;
    logic          reset_n;
    logic          nvram_download, nvram_upload, nvram_wr, nvram_rd;
    logic [AW-1:0] nvram_addr;
    logic [DW-1:0] nvram_dout, nvram_din;
    logic          nvram_upload_req;
    logic [15:0]   nvram_upload_index;
    logic [AW-1:0] core_addr;
    logic          core_wr, core_save, core_busy, dirty;
    logic [DW-1:0] core_wdata, core_rdata;

    always #5 clk_memory = ~clk_memory;

    nvram_responder #(.AW(AW), .DW(DW), .SAVE_IDX(3), .AUTOSAVE_CYCLES(16)) dut (
        .clk_memory(clk_memory), .reset_n(reset_n),
        .nvram_download(nvram_download), .nvram_upload(nvram_upload),
        .nvram_wr(nvram_wr), .nvram_addr(nvram_addr), .nvram_dout(nvram_dout),
        .nvram_rd(nvram_rd), .nvram_din(nvram_din),
        .nvram_upload_req(nvram_upload_req), .nvram_upload_index(nvram_upload_index),
        .core_addr(core_addr), .core_wr(core_wr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_save(core_save), .core_busy(core_busy),
        .dirty(dirty)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mem_m [int];
    bit            dirty_m;
    logic [DW-1:0] prev, cur, d;
    int            a;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_memory);
        #1;
    endtask

    task automatic dl_write(input int wa, input logic [DW-1:0] wd);
        nvram_wr = 1'b1; nvram_addr = AW'(wa); nvram_dout = wd;
        tick();
        nvram_wr = 1'b0;
        mem_m[wa] = wd;
    endtask

    task automatic core_write(input int wa, input logic [DW-1:0] wd);
        core_wr = 1'b1; core_addr = AW'(wa); core_wdata = wd;
        tick();
        core_wr = 1'b0;
        mem_m[wa] = wd;
        dirty_m = 1'b1;
    endtask

    task automatic core_read(input string tag, input int ra);
        core_addr = AW'(ra);
        tick();
        tick();
        chk(tag, core_rdata, mem_m[ra]);
    endtask

    task automatic do_upload(input bit collide);
        logic [DW-1:0] p, c, wd;
        int ra;
        core_write(32'h20, 8'h3C);
        core_save = 1'b1;
        tick();
        core_save = 1'b0;
        chk("ul_req_set", nvram_upload_req, 1);
        chk("ul_req_busy", core_busy, 0);
        tick();
        chk("ul_req_hold", nvram_upload_req, 1);
        nvram_upload = 1'b1;
        tick();
        chk("ul_req_drop", nvram_upload_req, 0);
        chk("ul_busy", core_busy, 1);
        p = '0;
        for (int j = 0; j < 9; j++) begin
            ra = (j == 0) ? 32'h20 : int'($urandom_range(0, 15));
            nvram_rd = 1'b1; nvram_addr = AW'(ra);
            c = mem_m[ra];
            tick();
            if (j > 0) chk("ul_rd", nvram_din, p);
            if (j == 1) chk("ul_rd_3c", nvram_din, 8'h3C);
            p = c;
        end
        nvram_rd = 1'b0;
        tick();
        chk("ul_rd_last", nvram_din, p);
        tick();
        tick();
        chk("ul_hold", nvram_din, p);
        nvram_upload = 1'b0;
        if (collide) begin
            wd = 8'($urandom);
            core_wr = 1'b1; core_addr = 5; core_wdata = wd;
        end
        tick();
        core_wr = 1'b0;
        if (collide) begin
            mem_m[5] = wd;
            dirty_m = 1'b1;
        end else begin
            dirty_m = 1'b0;
        end
        chk("ul_end_dirty", dirty, dirty_m);
        chk("ul_end_busy", core_busy, 0);
        chk("ul_end_req", nvram_upload_req, 0);
        if (collide) core_read("ul_collide_rd", 5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        nvram_download = 0; nvram_upload = 0; nvram_wr = 0; nvram_rd = 0;
        nvram_addr = '0; nvram_dout = '0;
        core_addr = '0; core_wr = 0; core_wdata = '0; core_save = 0;
        dirty_m = 1'b0;
        tick();
        tick();
        chk("rst_din", nvram_din, 0);
        chk("rst_rdata", core_rdata, 0);
        chk("rst_req", nvram_upload_req, 0);
        chk("rst_busy", core_busy, 0);
        chk("rst_dirty", dirty, 0);
        chk("upload_index", nvram_upload_index, 3);
        reset_n = 1'b1;
        tick();

        // save request with a clean RAM does nothing
        core_save = 1'b1;
        tick();
        core_save = 1'b0;
        chk("save_clean", nvram_upload_req, 0);

        core_write(32'h30, 8'($urandom));
        chk("dirty_set", dirty, 1);

        // download preloads 0..15 and 0x10; a core write meanwhile is dropped
        nvram_download = 1'b1;
        tick();
        chk("dl_busy", core_busy, 1);
        for (int i = 0; i < 16; i++) dl_write(i, 8'($urandom));
        dl_write(32'h10, 8'hA5);
        core_wr = 1'b1; core_addr = AW'(32'h10); core_wdata = 8'hFF;
        tick();
        core_wr = 1'b0;
        chk("dl_arb_busy", core_busy, 1);
        nvram_download = 1'b0;
        tick();
        dirty_m = 1'b0;
        chk("dl_idle_busy", core_busy, 0);
        chk("dl_dirty_clr", dirty, 0);
        core_addr = AW'(32'h10);
        tick();
        tick();
        chk("dl_rd_a5", core_rdata, 8'hA5);

        // bridge write outside DOWNLOAD is ignored
        nvram_wr = 1'b1; nvram_addr = 3; nvram_dout = ~mem_m[3];
        tick();
        nvram_wr = 1'b0;
        core_read("idle_bwr_ignored", 3);

        // random core traffic, read-before-write per cycle
        prev = '0;
        for (int i = 0; i < 200; i++) begin
            a = int'($urandom_range(0, 15));
            d = 8'($urandom);
            core_wr = 1'($urandom_range(0, 1));
            core_addr = AW'(a); core_wdata = d;
            cur = mem_m[a];
            tick();
            if (core_wr) begin
                mem_m[a] = d;
                dirty_m = 1'b1;
            end
            if (i > 0) chk("core_rd", core_rdata, prev);
            prev = cur;
        end
        core_wr = 1'b0;
        chk("dirty_rand", dirty, dirty_m);

        do_upload(1'b0);
        do_upload(1'b1);

        // reset in the middle of an upload
        core_write(32'h21, 8'($urandom));
        nvram_upload = 1'b1;
        tick();
        chk("mid_ul_busy", core_busy, 1);
        reset_n = 1'b0; nvram_upload = 1'b0;
        tick();
        reset_n = 1'b1;
        dirty_m = 1'b0;
        chk("mrst_din", nvram_din, 0);
        chk("mrst_rdata", core_rdata, 0);
        chk("mrst_req", nvram_upload_req, 0);
        chk("mrst_busy", core_busy, 0);
        chk("mrst_dirty", dirty, 0);
        core_addr = AW'(32'h20);
        tick();
        tick();
        chk("mrst_ram_3c", core_rdata, 8'h3C);

        // a level still high after reset re-enters the transfer
        nvram_upload = 1'b1; reset_n = 1'b0;
        tick();
        chk("rst_hi_busy", core_busy, 0);
        reset_n = 1'b1;
        tick();
        chk("rst_rejoin_busy", core_busy, 1);
        nvram_upload = 1'b0;
        tick();
        chk("rst_rejoin_exit", core_busy, 0);

        // download wins when both levels rise together
        nvram_download = 1'b1; nvram_upload = 1'b1;
        tick();
        chk("prio_busy", core_busy, 1);
        dl_write(32'h11, 8'($urandom));
        nvram_download = 1'b0; nvram_upload = 1'b0;
        tick();
        dirty_m = 1'b0;
        chk("prio_idle", core_busy, 0);
        chk("prio_dirty", dirty, dirty_m);
        core_read("prio_rd", 32'h11);

`ifdef NVRAM_AUTOSAVE_EN
        begin
            int k;
            core_write(32'h22, 8'($urandom));
            k = 0;
            while (!nvram_upload_req && k < 40) begin
                tick();
                k++;
            end
            chk("autosave_lat", k, 15);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
